// File: rtl/maze_pkg.sv
// Shared maze geometry, FSM states and neighbour address helper.
// TUNNEL_WRAP_EN (optional define) wraps row TUNNEL_ROW left/right edges through the ROM.
package maze_pkg;

    localparam int MAZE_W     = 28;
    localparam int MAZE_H     = 31;
    localparam int TUNNEL_ROW = 14;
    localparam int MAP_ADDR_W = 10;
    localparam int COORD_W    = 6;

    typedef enum logic [2:0] {
        IDLE,
        Q_UP,
        Q_DN,
        Q_LF,
        Q_RT,
        Q_LAST,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DN,
        DIR_LF,
        DIR_RT
    } dir_e;

    typedef struct packed {
        logic                  forced;
        logic [MAP_ADDR_W-1:0] addr;
    } nbr_t;

    function automatic logic in_grid(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (int'(x) < MAZE_W) && (int'(y) < MAZE_H);
    endfunction

    // Off-grid neighbours read as walls and park the ROM address at 0.
    function automatic nbr_t nbr_lookup(input dir_e dir, input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y);
        nbr_t n;
        int   nx;
        int   ny;
        nx = int'(x);
        ny = int'(y);
        case (dir)
            DIR_UP:  ny = ny - 1;
            DIR_DN:  ny = ny + 1;
            DIR_LF:  nx = nx - 1;
            default: nx = nx + 1;
        endcase
`ifdef TUNNEL_WRAP_EN
        if (ny == TUNNEL_ROW && nx == -1)     nx = MAZE_W - 1;
        if (ny == TUNNEL_ROW && nx == MAZE_W) nx = 0;
`endif
        if (nx < 0 || nx >= MAZE_W || ny < 0 || ny >= MAZE_H) begin
            n.forced = 1'b1;
            n.addr   = '0;
        end else begin
            n.forced = 1'b0;
            n.addr   = MAP_ADDR_W'(ny * MAZE_W + nx);
        end
        return n;
    endfunction

endpackage

// File: rtl/maze_wall_server_if.sv
// Query/response bundle between a requester (master) and the wall server (slave).
interface maze_wall_server_if;
    import maze_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               wall_up;
    logic               wall_down;
    logic               wall_left;
    logic               wall_right;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, wall_up, wall_down, wall_left, wall_right
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, wall_up, wall_down, wall_left, wall_right
    );

endinterface

// File: rtl/maze_wall_server.sv
// Answers "which neighbours of tile (x,y) are walls" by four reads of an external 1-bit maze ROM.
// Build option: TUNNEL_WRAP_EN (see maze_pkg).
module maze_wall_server
    import maze_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    maze_wall_server_if.slave     bus,
    output logic [MAP_ADDR_W-1:0] map_addr,
    input  logic                  map_data
);

    state_e               r_state;
    state_e               w_next;
    logic                 w_req_ready;
    logic                 w_rsp_valid;
    logic                 w_accept;
    logic                 w_req_in_grid;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic [MAP_ADDR_W-1:0] r_map_addr;
    logic                 r_up;
    logic                 r_dn;
    logic                 r_lf;
    logic [3:0]           r_walls;
    nbr_t                 w_first_up;
    nbr_t                 w_nbr_up;
    nbr_t                 w_nbr_dn;
    nbr_t                 w_nbr_lf;
    nbr_t                 w_nbr_rt;

    assign w_accept      = (r_state == IDLE) && bus.req_valid;
    assign w_req_in_grid = in_grid(bus.req_x, bus.req_y);

    // The first ROM address must be on the bus while in Q_UP, so it comes from the live request.
    assign w_first_up = nbr_lookup(DIR_UP, bus.req_x, bus.req_y);
    assign w_nbr_up   = nbr_lookup(DIR_UP, r_x, r_y);
    assign w_nbr_dn   = nbr_lookup(DIR_DN, r_x, r_y);
    assign w_nbr_lf   = nbr_lookup(DIR_LF, r_x, r_y);
    assign w_nbr_rt   = nbr_lookup(DIR_RT, r_x, r_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default before the case so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_next = w_req_in_grid ? Q_UP : RESP;
            end
            Q_UP:   w_next = Q_DN;
            Q_DN:   w_next = Q_LF;
            Q_LF:   w_next = Q_RT;
            Q_RT:   w_next = Q_LAST;
            Q_LAST: w_next = RESP;
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_map_addr <= '0;
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
            r_lf       <= 1'b0;
            r_walls    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x <= bus.req_x;
                        r_y <= bus.req_y;
                        if (w_req_in_grid) r_map_addr <= w_first_up.addr;
                        else               r_walls    <= 4'b1111;
                    end
                end
                Q_UP: r_map_addr <= w_nbr_dn.addr;
                // ROM data lags the address by one cycle, so each capture is one state late.
                Q_DN: begin
                    r_up       <= w_nbr_up.forced | map_data;
                    r_map_addr <= w_nbr_lf.addr;
                end
                Q_LF: begin
                    r_dn       <= w_nbr_dn.forced | map_data;
                    r_map_addr <= w_nbr_rt.addr;
                end
                Q_RT:   r_lf    <= w_nbr_lf.forced | map_data;
                Q_LAST: r_walls <= {r_up, r_dn, r_lf, w_nbr_rt.forced | map_data};
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.wall_up    = r_walls[3];
    assign bus.wall_down  = r_walls[2];
    assign bus.wall_left  = r_walls[1];
    assign bus.wall_right = r_walls[0];
    assign map_addr       = r_map_addr;

endmodule

// File: tb/tb_maze_wall_server.sv
// Scoreboard bench for maze_wall_server with a behavioural synchronous-read maze ROM.
module tb_maze_wall_server;

    localparam int W = 28;
    localparam int H = 31;
`ifdef TUNNEL_WRAP_EN
    localparam bit TUNNEL = 1'b1;
`else
    localparam bit TUNNEL = 1'b0;
`endif

    typedef struct {
        logic [3:0] walls;
        int         lat;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [9:0] map_addr;
    logic       map_data;
    logic       rom [0:W*H-1];
    exp_t       sb[$];
    int         n_chk;
    int         n_err;

    maze_wall_server_if bif ();

    maze_wall_server dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif),
        .map_addr (map_addr),
        .map_data (map_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) map_data <= (int'(map_addr) < W*H) ? rom[map_addr] : 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input int x, input int y);
        logic up, dn, lf, rt;
        if (x >= W || y >= H) return 4'b1111;
        up = (y == 0)     ? 1'b1 : rom[(y-1)*W + x];
        dn = (y == H - 1) ? 1'b1 : rom[(y+1)*W + x];
        if (x == 0)          lf = (TUNNEL && y == 14) ? rom[14*W + W - 1] : 1'b1;
        else                 lf = rom[y*W + x - 1];
        if (x == W - 1)      rt = (TUNNEL && y == 14) ? rom[14*W] : 1'b1;
        else                 rt = rom[y*W + x + 1];
        return {up, dn, lf, rt};
    endfunction

    function automatic int walls_now();
        return int'({bif.wall_up, bif.wall_down, bif.wall_left, bif.wall_right});
    endfunction

    // Latency is counted in edges after the accept edge; an out-of-range request
    // enters RESP on the accept edge itself.
    task automatic run_query(input int x, input int y, input int hold);
        exp_t       e;
        int         lat;
        logic [9:0] addr_before;
        bit         oob;
        oob     = (x >= W || y >= H);
        e.walls = model(x, y);
        e.lat   = oob ? 0 : 5;
        sb.push_back(e);

        @(negedge clk);
        chk("req_ready_idle", int'(bif.req_ready), 1);
        addr_before   = map_addr;
        bif.req_x     = 6'(x);
        bif.req_y     = 6'(y);
        bif.req_valid = 1'b1;
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        if (!oob) chk("up_addr", int'(map_addr), (y == 0) ? 0 : (y-1)*W + x);

        lat = 0;
        while (!bif.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("walls", walls_now(), int'(e.walls));
        if (oob) chk("map_addr_hold", int'(map_addr), int'(addr_before));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_walls", walls_now(), int'(e.walls));
            chk("bp_rsp_valid", int'(bif.rsp_valid), 1);
            chk("bp_req_ready", int'(bif.req_ready), 0);
            bif.req_x     = 6'($urandom_range(0, 63));
            bif.req_valid = ~bif.req_valid;
        end

        @(negedge clk);
        bif.req_valid = (hold > 0);
        bif.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.rsp_ready = 1'b0;
        bif.req_valid = 1'b0;
        chk("rsp_drop", int'(bif.rsp_valid), 0);
        chk("req_ready_after", int'(bif.req_ready), 1);
        chk("walls_kept", walls_now(), int'(e.walls));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_x     = '0;
        bif.req_y     = '0;
        bif.rsp_ready = 1'b0;
        for (int i = 0; i < W*H; i++) rom[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", int'(bif.req_ready), 1);
        chk("rst_rsp_valid", int'(bif.rsp_valid), 0);
        chk("rst_walls", walls_now(), 0);
        chk("rst_map_addr", int'(map_addr), 0);
        reset = 1'b0;

        rom[0*W + 1] = 1'b1;
        rom[2*W + 1] = 1'b0;
        rom[1*W + 0] = 1'b1;
        rom[1*W + 2] = 1'b0;
        rom[14*W + 0]  = 1'b0;
        rom[13*W + 27] = 1'b1;
        run_query(1, 1, 0);
        chk("q11_pattern", walls_now(), 4'b1010);
        run_query(27, 14, 0);
        chk("tunnel_right", int'(bif.wall_right), TUNNEL ? 0 : 1);
        run_query(0, 0, 0);
        chk("corner_up", int'(bif.wall_up), 1);
        chk("corner_left", int'(bif.wall_left), 1);
        run_query(28, 5, 0);
        run_query(1, 1, 10);

        // Reset while the query sits in Q_LF.
        @(negedge clk);
        bif.req_x     = 6'd1;
        bif.req_y     = 6'd1;
        bif.req_valid = 1'b1;
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_req_ready", int'(bif.req_ready), 1);
        chk("abort_map_addr", int'(map_addr), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", int'(bif.rsp_valid), 0);
        end
        reset = 1'b0;
        run_query(1, 1, 0);
        chk("post_abort", walls_now(), 4'b1010);

        for (int i = 0; i < W*H; i++) rom[i] = 1'($urandom_range(0, 1));
        run_query(0, 14, 0);
        run_query(27, 14, 0);
        run_query(0, 30, 0);
        run_query(27, 30, 2);
        run_query(5, 40, 0);
        for (int i = 0; i < 8; i++) run_query($urandom_range(0, W-1), $urandom_range(0, H-1), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
